// File: rtl/b03_requester_agent.sv
`default_nettype none
// b03_requester_agent: four clients request the b03 arbiter for a fixed tenure per
// pending job, and flag starvation and arbiter protocol errors. Rev 1.0
module b03_requester_agent #(
    parameter int TENURE = 4,
    parameter int JOBW   = 4,
    parameter int STARVE = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [3:0]        job_push,
    input  logic [3:0]        grant_i,
    output logic [3:0]        request_o,
    output logic [4*JOBW-1:0] pending_o,
    output logic [3:0]        done_o,
    output logic [3:0]        starve_o,
    output logic [3:0]        ovf_o,
    output logic [1:0]        err_o,
    output logic              busy_o
);

    localparam int TW = (TENURE > 1) ? $clog2(TENURE) : 1;
    localparam int WW = $clog2(STARVE);
    localparam logic [TW-1:0]   TLOAD = TW'(TENURE - 1);
    localparam logic [WW-1:0]   WLAST = WW'(STARVE - 1);
    localparam logic [JOBW-1:0] CMAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_REL  = 2'd3
    } state_t;

    logic [3:0] busy_nxt;
    logic [3:0] idle_or_rel;

    for (genvar k = 0; k < 4; k++) begin : g_client
        state_t          state, state_nxt;
        logic [TW-1:0]   tcnt, tcnt_nxt;
        logic [WW-1:0]   wcnt, wcnt_nxt;
        logic [JOBW-1:0] cnt;
        logic            req_q, done_q, starve_q, ovf_q;
        logic            push, dec;

        assign push = job_push[k];
        assign dec  = (state == S_REL);

        always_comb begin
            state_nxt = state;
            tcnt_nxt  = tcnt;
            wcnt_nxt  = wcnt;
            case (state)
                S_IDLE: begin
                    if (cnt != '0) begin
                        state_nxt = S_REQ;
                        wcnt_nxt  = '0;
                    end
                end
                S_REQ: begin
                    if (grant_i[k]) begin
                        state_nxt = S_HOLD;
                        tcnt_nxt  = TLOAD;
                    end else if (wcnt != WLAST) begin
                        wcnt_nxt = wcnt + WW'(1);
                    end
                end
                S_HOLD: begin
                    if (tcnt == '0) state_nxt = S_REL;
                    else            tcnt_nxt  = tcnt - TW'(1);
                end
                S_REL:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end

        // Output flops are loaded from the next state so they track the FSM exactly.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                state    <= S_IDLE;
                tcnt     <= '0;
                wcnt     <= '0;
                cnt      <= '0;
                req_q    <= 1'b0;
                done_q   <= 1'b0;
                starve_q <= 1'b0;
                ovf_q    <= 1'b0;
            end else begin
                state  <= state_nxt;
                tcnt   <= tcnt_nxt;
                wcnt   <= wcnt_nxt;
                req_q  <= (state_nxt == S_REQ) || (state_nxt == S_HOLD);
                done_q <= (state_nxt == S_REL);
                if (state == S_REQ) begin
                    if (grant_i[k])         starve_q <= 1'b0;
                    else if (wcnt == WLAST) starve_q <= 1'b1;
                end
                if (push && !dec) begin
                    if (cnt == CMAX) ovf_q <= 1'b1;
                    else             cnt   <= cnt + JOBW'(1);
                end else if (dec && !push) begin
                    cnt <= cnt - JOBW'(1);
                end
            end
        end

        assign request_o[k]              = req_q;
        assign done_o[k]                 = done_q;
        assign starve_o[k]               = starve_q;
        assign ovf_o[k]                  = ovf_q;
        assign pending_o[k*JOBW +: JOBW] = cnt;
        assign busy_nxt[k]               = (state_nxt != S_IDLE);
        assign idle_or_rel[k]            = (state == S_IDLE) || (state == S_REL);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err_o  <= 2'b00;
            busy_o <= 1'b0;
        end else begin
            busy_o <= |busy_nxt;
            // x & (x-1) is nonzero exactly when more than one bit is set
            if (|(grant_i & (grant_i - 4'd1))) err_o[0] <= 1'b1;
            if (|(grant_i & idle_or_rel))     err_o[1] <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_b03_requester_agent.sv
`default_nettype none
// tb_b03_requester_agent: directed scenarios for the b03 requester agent. Rev 1.0
module tb_b03_requester_agent;

    logic        clock;
    logic        reset_n;
    logic [3:0]  job_push;
    logic [3:0]  grant_i;
    logic [3:0]  request_o;
    logic [15:0] pending_o;
    logic [3:0]  done_o;
    logic [3:0]  starve_o;
    logic [3:0]  ovf_o;
    logic [1:0]  err_o;
    logic        busy_o;

    int vectors;
    int miscompares;

    b03_requester_agent #(.TENURE(4), .JOBW(4), .STARVE(64)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .job_push  (job_push),
        .grant_i   (grant_i),
        .request_o (request_o),
        .pending_o (pending_o),
        .done_o    (done_o),
        .starve_o  (starve_o),
        .ovf_o     (ovf_o),
        .err_o     (err_o),
        .busy_o    (busy_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        job_push = 4'b0000;
        grant_i  = 4'b0000;
        step();
        step();
        vectors++; if (request_o !== 4'b0000) begin miscompares++; $display("FAIL rst_request: got %h expected 0", request_o); end
        vectors++; if (pending_o !== 16'h0000) begin miscompares++; $display("FAIL rst_pending: got %h expected 0", pending_o); end
        vectors++; if (done_o !== 4'b0000) begin miscompares++; $display("FAIL rst_done: got %h expected 0", done_o); end
        vectors++; if (starve_o !== 4'b0000) begin miscompares++; $display("FAIL rst_starve: got %h expected 0", starve_o); end
        vectors++; if (ovf_o !== 4'b0000) begin miscompares++; $display("FAIL rst_ovf: got %h expected 0", ovf_o); end
        vectors++; if (err_o !== 2'b00) begin miscompares++; $display("FAIL rst_err: got %b expected 00", err_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_job();
        int hi;
        int dones;
        job_push = 4'b0001;
        step();
        job_push = 4'b0000;
        vectors++; if (pending_o[3:0] !== 4'd1) begin miscompares++; $display("FAIL single_pend_after_push: got %0d expected 1", pending_o[3:0]); end
        vectors++; if (request_o !== 4'b0000) begin miscompares++; $display("FAIL single_req_latency: got %b expected 0000", request_o); end
        step();
        vectors++; if (request_o !== 4'b0001) begin miscompares++; $display("FAIL single_req_rise: got %b expected 0001", request_o); end
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", busy_o); end
        hi = 1;
        dones = 0;
        grant_i = request_o & 4'b0001;
        for (int i = 0; i < 20; i++) begin
            step();
            if (request_o[0]) hi++;
            if (done_o[0]) dones++;
            grant_i = request_o & 4'b0001;
        end
        vectors++; if (hi !== 5) begin miscompares++; $display("FAIL single_req_cycles: got %0d expected 5", hi); end
        vectors++; if (dones !== 1) begin miscompares++; $display("FAIL single_done_pulses: got %0d expected 1", dones); end
        vectors++; if (pending_o[3:0] !== 4'd0) begin miscompares++; $display("FAIL single_pend_final: got %0d expected 0", pending_o[3:0]); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL single_busy_final: got %b expected 0", busy_o); end
        vectors++; if (err_o !== 2'b00) begin miscompares++; $display("FAIL single_err: got %b expected 00", err_o); end
    endtask

    task automatic test_back_to_back();
        int dones;
        int gaps;
        int low_run;
        int decs;
        logic prev_req;
        logic [3:0] prev_pend;
        for (int i = 0; i < 3; i++) begin
            job_push = 4'b0100;
            step();
        end
        job_push = 4'b0000;
        vectors++; if (pending_o[11:8] !== 4'd3) begin miscompares++; $display("FAIL b2b_pend_start: got %0d expected 3", pending_o[11:8]); end
        dones = 0; gaps = 0; low_run = 0; decs = 0;
        prev_req  = request_o[2];
        prev_pend = pending_o[11:8];
        grant_i = request_o & 4'b0100;
        for (int i = 0; i < 80; i++) begin
            step();
            if (done_o[2]) dones++;
            if (!request_o[2]) begin
                low_run++;
            end else begin
                if (!prev_req) begin
                    gaps++;
                    vectors++; if (low_run !== 2) begin miscompares++; $display("FAIL b2b_gap: got %0d expected 2", low_run); end
                end
                low_run = 0;
            end
            if (pending_o[11:8] !== prev_pend) begin
                decs++;
                vectors++; if (pending_o[11:8] !== prev_pend - 4'd1) begin miscompares++; $display("FAIL b2b_pend_step: got %0d expected %0d", pending_o[11:8], prev_pend - 4'd1); end
            end
            prev_req  = request_o[2];
            prev_pend = pending_o[11:8];
            grant_i = request_o & 4'b0100;
        end
        vectors++; if (dones !== 3) begin miscompares++; $display("FAIL b2b_done_pulses: got %0d expected 3", dones); end
        vectors++; if (gaps !== 2) begin miscompares++; $display("FAIL b2b_gap_count: got %0d expected 2", gaps); end
        vectors++; if (decs !== 3) begin miscompares++; $display("FAIL b2b_dec_count: got %0d expected 3", decs); end
        vectors++; if (pending_o[11:8] !== 4'd0) begin miscompares++; $display("FAIL b2b_pend_final: got %0d expected 0", pending_o[11:8]); end
    endtask

    task automatic test_starvation();
        job_push = 4'b0010;
        step();
        job_push = 4'b0000;
        step();
        vectors++; if (request_o !== 4'b0010) begin miscompares++; $display("FAIL starve_req_rise: got %b expected 0010", request_o); end
        repeat (63) step();
        vectors++; if (starve_o !== 4'b0000) begin miscompares++; $display("FAIL starve_early: got %b expected 0000", starve_o); end
        step();
        vectors++; if (starve_o !== 4'b0010) begin miscompares++; $display("FAIL starve_set: got %b expected 0010", starve_o); end
        repeat (5) step();
        vectors++; if (starve_o !== 4'b0010) begin miscompares++; $display("FAIL starve_hold: got %b expected 0010", starve_o); end
        grant_i = 4'b0010;
        step();
        vectors++; if (starve_o !== 4'b0000) begin miscompares++; $display("FAIL starve_clear: got %b expected 0000", starve_o); end
        vectors++; if (request_o !== 4'b0010) begin miscompares++; $display("FAIL starve_hold_req: got %b expected 0010", request_o); end
        for (int i = 0; i < 20; i++) begin
            grant_i = request_o & 4'b0010;
            step();
        end
        grant_i = 4'b0000;
        vectors++; if (pending_o[7:4] !== 4'd0) begin miscompares++; $display("FAIL starve_pend_final: got %0d expected 0", pending_o[7:4]); end
        vectors++; if (err_o !== 2'b00) begin miscompares++; $display("FAIL starve_err: got %b expected 00", err_o); end
    endtask

    task automatic test_overflow();
        logic saw_done;
        job_push = 4'b1000;
        repeat (15) step();
        vectors++; if (pending_o[15:12] !== 4'd15) begin miscompares++; $display("FAIL ovf_pend_15: got %0d expected 15", pending_o[15:12]); end
        vectors++; if (ovf_o !== 4'b0000) begin miscompares++; $display("FAIL ovf_not_yet: got %b expected 0000", ovf_o); end
        step();
        job_push = 4'b0000;
        vectors++; if (pending_o[15:12] !== 4'd15) begin miscompares++; $display("FAIL ovf_pend_sat: got %0d expected 15", pending_o[15:12]); end
        vectors++; if (ovf_o !== 4'b1000) begin miscompares++; $display("FAIL ovf_set: got %b expected 1000", ovf_o); end
        saw_done = 1'b0;
        grant_i = request_o & 4'b1000;
        for (int i = 0; i < 40; i++) begin
            step();
            grant_i = request_o & 4'b1000;
            if (done_o[3]) begin
                saw_done = 1'b1;
                break;
            end
        end
        vectors++; if (saw_done !== 1'b1) begin miscompares++; $display("FAIL ovf_reach_rel: got %b expected 1", saw_done); end
        job_push = 4'b1000;
        step();
        job_push = 4'b0000;
        vectors++; if (pending_o[15:12] !== 4'd15) begin miscompares++; $display("FAIL ovf_push_and_rel: got %0d expected 15", pending_o[15:12]); end
        vectors++; if (ovf_o !== 4'b1000) begin miscompares++; $display("FAIL ovf_sticky: got %b expected 1000", ovf_o); end
    endtask

    task automatic test_errors();
        grant_i  = 4'b0000;
        job_push = 4'b0000;
        reset_n  = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        vectors++; if (err_o !== 2'b00) begin miscompares++; $display("FAIL err_after_rst: got %b expected 00", err_o); end
        vectors++; if (ovf_o !== 4'b0000) begin miscompares++; $display("FAIL ovf_after_rst: got %b expected 0000", ovf_o); end
        grant_i = 4'b1000;
        step();
        grant_i = 4'b0000;
        vectors++; if (err_o !== 2'b10) begin miscompares++; $display("FAIL err_idle_grant: got %b expected 10", err_o); end
        vectors++; if (request_o !== 4'b0000) begin miscompares++; $display("FAIL err_no_fsm_effect: got %b expected 0000", request_o); end
        step();
        grant_i = 4'b0110;
        step();
        grant_i = 4'b0000;
        vectors++; if (err_o !== 2'b11) begin miscompares++; $display("FAIL err_multi_hot: got %b expected 11", err_o); end
        repeat (3) step();
        vectors++; if (err_o !== 2'b11) begin miscompares++; $display("FAIL err_sticky: got %b expected 11", err_o); end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        vectors++; if (err_o !== 2'b00) begin miscompares++; $display("FAIL err_cleared: got %b expected 00", err_o); end
        step();
    endtask

    task automatic test_reset_in_hold();
        job_push = 4'b0001;
        step();
        job_push = 4'b0000;
        step();
        grant_i = 4'b0001;
        step();
        step();
        vectors++; if (request_o !== 4'b0001) begin miscompares++; $display("FAIL rih_in_hold: got %b expected 0001", request_o); end
        grant_i = 4'b0000;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        vectors++; if (request_o !== 4'b0000) begin miscompares++; $display("FAIL rih_request: got %b expected 0000", request_o); end
        vectors++; if (pending_o !== 16'h0000) begin miscompares++; $display("FAIL rih_pending: got %h expected 0000", pending_o); end
        vectors++; if (done_o !== 4'b0000) begin miscompares++; $display("FAIL rih_done: got %b expected 0000", done_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rih_busy: got %b expected 0", busy_o); end
        step();
        vectors++; if (done_o !== 4'b0000) begin miscompares++; $display("FAIL rih_done_after: got %b expected 0000", done_o); end
        vectors++; if (request_o !== 4'b0000) begin miscompares++; $display("FAIL rih_req_after: got %b expected 0000", request_o); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_job();
        test_back_to_back();
        test_starvation();
        test_overflow();
        test_errors();
        test_reset_in_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
